// File: rtl/spi_responder_if.sv
// rtl/spi_responder_if.sv - rx/tx word streams between spi_responder and its host
interface spi_responder_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] rx_tdata;
    logic                  rx_tvalid;
    logic                  rx_tready;
    logic [DATA_WIDTH-1:0] tx_tdata;
    logic                  tx_tvalid;
    logic                  tx_tready;

    modport slave (
        output rx_tdata, rx_tvalid,
        input  rx_tready,
        input  tx_tdata, tx_tvalid,
        output tx_tready
    );

    modport master (
        input  rx_tdata, rx_tvalid,
        output rx_tready,
        output tx_tdata, tx_tvalid,
        input  tx_tready
    );
endinterface

// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder bridging the serial bus to rx/tx word streams
// Optional status outputs (overrun, frame_count) built when SPI_RESPONDER_STATUS_EN is defined.
module spi_responder #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD   = 'hFF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    spi_responder_if.slave        stream
`ifdef SPI_RESPONDER_STATUS_EN
    ,
    output logic                  overrun,
    output logic [15:0]           frame_count
`endif
);

    localparam int              CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [2:0]      FLUSH_DONE = 3'(SYNC_STAGES);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall;

    logic [2:0]             flush_cnt;
    logic                   armed;

    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_WIDTH-1:0]  rx_shift, tx_shift, rx_word_next;
    logic                   reload_pending;

    logic                   load_tx, shift_tx, sample_rx, word_done, abort;

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;

    assign rx_word_next = {rx_shift[DATA_WIDTH-2:0], mosi_s};

    assign miso             = tx_shift[DATA_WIDTH-1];
    assign miso_oe          = (state == SHIFT) & ~cs_s;
    assign stream.tx_tready = load_tx & stream.tx_tvalid & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_d     <= sck_s;
        end
    end

    // The synchronizer reload makes a held-low cs_n look like a fresh falling edge after reset;
    // only respond once cs_n has been seen high with the chain carrying real pad values.
    always_ff @(posedge clk) begin
        if (reset) begin
            flush_cnt <= '0;
            armed     <= 1'b0;
        end else begin
            if (flush_cnt != FLUSH_DONE)
                flush_cnt <= flush_cnt + 3'd1;
            if ((flush_cnt == FLUSH_DONE) && cs_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_tx    = 1'b0;
        shift_tx   = 1'b0;
        sample_rx  = 1'b0;
        word_done  = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (armed && !cs_s) begin
                    state_next = SHIFT;
                    load_tx    = 1'b1;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    state_next = IDLE;
                    abort      = 1'b1;
                end else if (sck_rise) begin
                    sample_rx = 1'b1;
                    word_done = (bit_cnt == LAST_BIT);
                end else if (sck_fall) begin
                    if (reload_pending)
                        load_tx = 1'b1;
                    else
                        shift_tx = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= '0;
            rx_shift       <= '0;
            tx_shift       <= '0;
            reload_pending <= 1'b0;
        end else begin
            if (load_tx)
                tx_shift <= stream.tx_tvalid ? stream.tx_tdata : FILL_WORD;
            else if (shift_tx)
                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};

            if (abort) begin
                bit_cnt        <= '0;
                rx_shift       <= '0;
                reload_pending <= 1'b0;
            end else if (sample_rx) begin
                rx_shift       <= rx_word_next;
                bit_cnt        <= word_done ? '0 : bit_cnt + 1'b1;
                reload_pending <= word_done;
            end else if (load_tx) begin
                reload_pending <= 1'b0;
            end
        end
    end

    // A completed word replaces the held one only if the slot is empty or being drained.
    always_ff @(posedge clk) begin
        if (reset) begin
            stream.rx_tdata  <= '0;
            stream.rx_tvalid <= 1'b0;
        end else if (word_done && (!stream.rx_tvalid || stream.rx_tready)) begin
            stream.rx_tdata  <= rx_word_next;
            stream.rx_tvalid <= 1'b1;
        end else if (stream.rx_tready) begin
            stream.rx_tvalid <= 1'b0;
        end
    end

`ifdef SPI_RESPONDER_STATUS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            frame_count <= '0;
        end else if (word_done) begin
            frame_count <= frame_count + 16'd1;
            if (stream.rx_tvalid && !stream.rx_tready)
                overrun <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - self-checking bench for spi_responder with a queue-based stream model
module tb_spi_responder;
    localparam int HALF = 6;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0;
    logic cs_n = 1'b1;
    logic mosi = 1'b0;
    logic miso, miso_oe;
`ifdef SPI_RESPONDER_STATUS_EN
    logic        overrun;
    logic [15:0] frame_count;
`endif

    spi_responder_if #(.DATA_WIDTH(8)) sif ();

    spi_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2), .FILL_WORD(8'hFF)) dut (
        .clk(clk), .reset(reset), .sck(sck), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .stream(sif)
`ifdef SPI_RESPONDER_STATUS_EN
        , .overrun(overrun), .frame_count(frame_count)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] tx_q[$];
    logic [7:0] got_rx[$];
    logic [7:0] mosi_words[$];
    logic [7:0] miso_words[$];
    int         tready_cnt;
    logic       oe_bad;

    task automatic drive_tx();
        sif.tx_tvalid = (tx_q.size() != 0);
        sif.tx_tdata  = (tx_q.size() != 0) ? tx_q[0] : 8'($urandom);
    endtask

    task automatic tick();
        logic pop;
        @(negedge clk);
        pop = sif.tx_tready && sif.tx_tvalid;
        if (sif.tx_tready) tready_cnt++;
        if (sif.rx_tvalid && sif.rx_tready) got_rx.push_back(sif.rx_tdata);
        @(posedge clk);
        #1;
        if (pop) void'(tx_q.pop_front());
        drive_tx();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic spi_bits(input logic [7:0] out, input int nbits, output logic [7:0] in);
        in = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = out[7-i];
            ticks(HALF);
            in[7-i] = miso;
            if (!miso_oe) oe_bad = 1'b1;
            sck = 1'b1;
            ticks(HALF);
            sck = 1'b0;
        end
    endtask

    task automatic run_burst();
        logic [7:0] r;
        miso_words.delete();
        cs_n = 1'b0;
        foreach (mosi_words[i]) begin
            spi_bits(mosi_words[i], 8, r);
            miso_words.push_back(r);
        end
        ticks(HALF);
        cs_n = 1'b1;
        ticks(3 * HALF);
    endtask

    task automatic start_test(input logic ready);
        got_rx.delete();
        tready_cnt = 0;
        oe_bad = 1'b0;
        sif.rx_tready = ready;
        drive_tx();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ticks(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.rx_tready = 1'b0;
        drive_tx();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b expected 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        checks++; if (sif.rx_tvalid !== 1'b0) begin errors++; $display("FAIL reset_rx_tvalid: got %b expected 0", sif.rx_tvalid); end
        checks++; if (sif.rx_tdata !== 8'h00) begin errors++; $display("FAIL reset_rx_tdata: got %h expected 00", sif.rx_tdata); end
        checks++; if (sif.tx_tready !== 1'b0) begin errors++; $display("FAIL reset_tx_tready: got %b expected 0", sif.tx_tready); end
`ifdef SPI_RESPONDER_STATUS_EN
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
`endif
        reset = 1'b0;
        ticks(4);
    endtask

    task automatic test_basic();
        start_test(1'b1);
        tx_q = '{8'h3C};
        drive_tx();
        mosi_words = '{8'hA5};
        run_burst();
        checks++; if (miso_words[0] !== 8'h3C) begin errors++; $display("FAIL basic_miso: got %h expected 3c", miso_words[0]); end
        checks++; if (got_rx.size() != 1 || got_rx[0] !== 8'hA5) begin errors++; $display("FAIL basic_rx: got %0d beats first %h expected 1 beat a5", got_rx.size(), (got_rx.size() != 0) ? got_rx[0] : 8'hxx); end
        checks++; if (tready_cnt != 1) begin errors++; $display("FAIL basic_tready: got %0d pulses expected 1", tready_cnt); end
        checks++; if (oe_bad !== 1'b0) begin errors++; $display("FAIL basic_oe_active: got low during frame expected high"); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_idle: got %b expected 0", miso_oe); end
    endtask

    task automatic test_fill();
        start_test(1'b1);
        mosi_words = '{8'h12};
        run_burst();
        checks++; if (miso_words[0] !== 8'hFF) begin errors++; $display("FAIL fill_miso: got %h expected ff", miso_words[0]); end
        checks++; if (got_rx.size() != 1 || got_rx[0] !== 8'h12) begin errors++; $display("FAIL fill_rx: got %0d beats expected 1 beat 12", got_rx.size()); end
        checks++; if (tready_cnt != 0) begin errors++; $display("FAIL fill_tready: got %0d pulses expected 0", tready_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_tx[3] = '{8'h81, 8'h82, 8'h83};
        logic [7:0] exp_rx[3] = '{8'h01, 8'h02, 8'h03};
        start_test(1'b1);
        tx_q = '{8'h81, 8'h82, 8'h83};
        drive_tx();
        mosi_words = '{8'h01, 8'h02, 8'h03};
        run_burst();
        for (int i = 0; i < 3; i++) begin
            checks++; if (miso_words[i] !== exp_tx[i]) begin errors++; $display("FAIL b2b_miso[%0d]: got %h expected %h", i, miso_words[i], exp_tx[i]); end
        end
        checks++; if (got_rx.size() != 3) begin errors++; $display("FAIL b2b_rx_count: got %0d expected 3", got_rx.size()); end
        for (int i = 0; i < 3 && i < got_rx.size(); i++) begin
            checks++; if (got_rx[i] !== exp_rx[i]) begin errors++; $display("FAIL b2b_rx[%0d]: got %h expected %h", i, got_rx[i], exp_rx[i]); end
        end
        checks++; if (tready_cnt != 3) begin errors++; $display("FAIL b2b_tready: got %0d pulses expected 3", tready_cnt); end
    endtask

    task automatic test_overrun();
        pulse_reset();
        start_test(1'b0);
        mosi_words = '{8'h11, 8'h22};
        run_burst();
        checks++; if (sif.rx_tvalid !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid: got %b expected 1", sif.rx_tvalid); end
        checks++; if (sif.rx_tdata !== 8'h11) begin errors++; $display("FAIL ovr_hold_data: got %h expected 11", sif.rx_tdata); end
`ifdef SPI_RESPONDER_STATUS_EN
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        checks++; if (frame_count !== 16'd2) begin errors++; $display("FAIL ovr_frame_count: got %0d expected 2", frame_count); end
`endif
        sif.rx_tready = 1'b1;
        ticks(3);
        checks++; if (sif.rx_tvalid !== 1'b0) begin errors++; $display("FAIL ovr_drain_valid: got %b expected 0", sif.rx_tvalid); end
        checks++; if (got_rx.size() != 1 || got_rx[0] !== 8'h11) begin errors++; $display("FAIL ovr_drain_beat: got %0d beats expected 1 beat 11", got_rx.size()); end
    endtask

    task automatic test_partial();
        logic [7:0] r;
        start_test(1'b1);
        cs_n = 1'b0;
        spi_bits(8'hE7, 5, r);
        ticks(HALF);
        cs_n = 1'b1;
        ticks(3 * HALF);
        checks++; if (got_rx.size() != 0) begin errors++; $display("FAIL partial_no_beat: got %0d beats expected 0", got_rx.size()); end
        mosi_words = '{8'h5A};
        run_burst();
        checks++; if (got_rx.size() != 1 || got_rx[0] !== 8'h5A) begin errors++; $display("FAIL partial_then_full: got %0d beats expected 1 beat 5a", got_rx.size()); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] r;
        start_test(1'b1);
        tx_q = '{8'h96};
        drive_tx();
        cs_n = 1'b0;
        spi_bits(8'hF0, 3, r);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (miso !== 1'b0 || miso_oe !== 1'b0) begin errors++; $display("FAIL midrst_pins: got miso=%b oe=%b expected 0 0", miso, miso_oe); end
        checks++; if (sif.rx_tvalid !== 1'b0 || sif.rx_tdata !== 8'h00 || sif.tx_tready !== 1'b0) begin errors++; $display("FAIL midrst_stream: got valid=%b data=%h ready=%b expected 0 00 0", sif.rx_tvalid, sif.rx_tdata, sif.tx_tready); end
        reset = 1'b0;
        tx_q.delete();
        drive_tx();
        spi_bits(8'hAA, 5, r);
        checks++; if (oe_bad !== 1'b1) begin errors++; $display("FAIL midrst_wait_cs: got oe high after reset expected low until new cs_n fall"); end
        ticks(HALF);
        cs_n = 1'b1;
        ticks(3 * HALF);
        checks++; if (got_rx.size() != 0) begin errors++; $display("FAIL midrst_no_beat: got %0d beats expected 0", got_rx.size()); end
        mosi_words = '{8'hC3};
        run_burst();
        checks++; if (got_rx.size() != 1 || got_rx[0] !== 8'hC3) begin errors++; $display("FAIL midrst_next_frame: got %0d beats expected 1 beat c3", got_rx.size()); end
        checks++; if (miso_words[0] !== 8'hFF) begin errors++; $display("FAIL midrst_next_miso: got %h expected ff", miso_words[0]); end
    endtask

    task automatic test_random();
        logic [7:0] supply[$];
        int n, k;
        for (int it = 0; it < 4; it++) begin
            start_test(1'b1);
            n = $urandom_range(1, 3);
            k = $urandom_range(0, n);
            supply.delete();
            mosi_words.delete();
            for (int i = 0; i < k; i++) supply.push_back(8'($urandom));
            for (int i = 0; i < n; i++) mosi_words.push_back(8'($urandom));
            tx_q = supply;
            drive_tx();
            run_burst();
            for (int i = 0; i < n; i++) begin
                logic [7:0] exp_m;
                exp_m = (i < k) ? supply[i] : 8'hFF;
                checks++; if (miso_words[i] !== exp_m) begin errors++; $display("FAIL rand%0d_miso[%0d]: got %h expected %h", it, i, miso_words[i], exp_m); end
            end
            checks++; if (got_rx.size() != n) begin errors++; $display("FAIL rand%0d_rx_count: got %0d expected %0d", it, got_rx.size(), n); end
            for (int i = 0; i < n && i < got_rx.size(); i++) begin
                checks++; if (got_rx[i] !== mosi_words[i]) begin errors++; $display("FAIL rand%0d_rx[%0d]: got %h expected %h", it, i, got_rx[i], mosi_words[i]); end
            end
            checks++; if (tready_cnt != k) begin errors++; $display("FAIL rand%0d_tready: got %0d expected %0d", it, tready_cnt, k); end
        end
    endtask

    initial begin
        sif.rx_tready = 1'b0;
        sif.tx_tvalid = 1'b0;
        sif.tx_tdata  = 8'h00;
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_overrun();
        test_partial();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spi_responder.md
SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per SPI frame and per stream beat.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sck, cs_n and mosi; legal range 2..4.
REQ-003 SHALL have parameter FILL_WORD, default 'hFF, word shifted out when no tx data is available.
REQ-004 clk  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 sck  input  1  SPI clock from the external master; asynchronous to clk.
REQ-007 cs_n  input  1  active-low chip select from the master.
REQ-008 mosi  input  1  serial data from the master.
REQ-009 miso  output  1  serial data to the master.
REQ-010 miso_oe  output  1  output enable for the miso pad driver; high only while the synchronized cs_n is low.
REQ-011 rx_tdata / rx_tvalid / rx_tready  output / output / input  DATA_WIDTH / 1 / 1  AXI-stream source of received words.
REQ-012 tx_tdata / tx_tvalid / tx_tready  input / input / output  DATA_WIDTH / 1 / 1  AXI-stream sink of words to transmit.

Function
REQ-013 SHALL implement SPI mode 0 (CPOL=0, CPHA=0), MSB first: sample mosi on sck rise, update miso on sck fall.
REQ-014 SHALL pass sck, cs_n and mosi through SYNC_STAGES flops, then detect sck edges by comparing the synchronized value with one further registered copy.
REQ-015 SHALL operate correctly for clk frequency >= 8x sck frequency; behaviour below that ratio is undefined.
REQ-016 States: IDLE (cs_n high), SHIFT (cs_n low, counting bits).
REQ-017 IDLE->SHIFT on synchronized cs_n falling; SHIFT->IDLE on synchronized cs_n rising, from any bit position.
REQ-018 On IDLE->SHIFT, if tx_tvalid, SHALL load tx_tdata into the tx shift register and assert tx_tready for exactly that one cycle; otherwise SHALL load FILL_WORD without asserting tx_tready.
REQ-019 miso SHALL equal tx shift register MSB; the loaded MSB is visible on the cycle after load.
REQ-020 Bit counter SHALL count sck rising edges 0..DATA_WIDTH-1 and wrap to 0 after the last bit.
REQ-021 On the rising edge completing a word, the assembled word SHALL be written to rx_tdata and rx_tvalid asserted on the next clk cycle; latency from the pad edge is at most SYNC_STAGES+2 clk cycles.
REQ-022 rx_tvalid SHALL hold with rx_tdata stable until rx_tready is sampled high; it then deasserts unless a new word completes on the same cycle, in which case the new word is presented with rx_tvalid kept high.
REQ-023 If a word completes while rx_tvalid is high and rx_tready is low, the new word SHALL be dropped, the held word kept, and an overrun recorded (REQ-031).
REQ-024 On the first sck falling edge after a word completes (counter wrapped to 0), the next tx word SHALL be loaded per REQ-018 rules, giving back-to-back frames within one cs_n assertion.
REQ-025 Other sck falling edges in SHIFT SHALL shift the tx register left by one bit.
REQ-026 cs_n rising mid-word SHALL discard the partial rx word, reset the bit counter, and not assert rx_tvalid; a tx word already popped is lost.
REQ-027 sck edges while cs_n is high SHALL be ignored.

Reset
REQ-028 While reset is high, on the next clk edge: state IDLE, counter 0, shift registers 0, synchronizers loaded with idle values (sck 0, cs_n 1, mosi 0).
REQ-029 Output reset values: miso 0, miso_oe 0, rx_tvalid 0, rx_tdata 0, tx_tready 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame; after release, the block waits for a new cs_n falling edge before it responds.

Configuration
REQ-031 With macro SPI_RESPONDER_STATUS_EN defined:
- adds outputs overrun (1 bit), sticky, set per REQ-023, cleared only by reset.
- adds frame_count (16 bits): increments on every completed word, including dropped ones, and wraps at 16'hFFFF->0.
- without the macro, these ports and their logic are absent, and overruns are silent.

Verification
REQ-032 Master sends 0xA5 with tx 0x3C queued and rx_tready=1 -> master reads 0x3C; rx beat 0xA5; one tx_tready pulse.
REQ-033 tx_tvalid=0, master sends 0x12 -> master reads 0xFF; rx beat 0x12; tx_tready never asserted.
REQ-034 Three back-to-back words 0x01,0x02,0x03 in one cs_n assertion, tx 0x81,0x82,0x83 queued -> master reads 0x81,0x82,0x83; rx beats 0x01,0x02,0x03 in order.
REQ-035 rx_tready=0, two words 0x11 then 0x22 -> rx_tdata holds 0x11; 0x22 dropped; with STATUS_EN, overrun=1 and frame_count=2.
REQ-036 cs_n deasserted after 5 bits, then full frame 0x5A -> no beat from the partial frame; single rx beat 0x5A.
REQ-037 reset pulsed after bit 3 of a frame -> all outputs at REQ-029 values; next full frame 0xC3 received correctly.
